adder_settle_monitor: RTL and testbench
=======================================

// Module: adder_settle_monitor
// PURPOSE
//  Synthesizable response-side monitor for the WIDTH-bit gate-level adders (rca_gl/cla_gl class).
//  Samples applied stimulus {a,b,c0} and DUT outputs {c,s} every clock, and computes the golden sum internally.
//  Measures cycles from each input transition until the DUT output equals the golden sum.
//  Tracks max settle time and the worst transition; flags timeouts and (optionally) post-settle glitches.
// PARAMETERS
//  WIDTH    3   operand width of a, b, s
//  TIMEOUT  63  settle-cycle limit before declaring timeout (<= 2**CNT_W-1)
//  CNT_W    8   width of settle counters
// PORTS
//  clk           in   1          rising-edge clock
//  rst_n         in   1          async active-low reset
//  en            in   1          measurement enable
//  a, b          in   WIDTH      operands as applied to DUT
//  c0            in   1          carry-in as applied to DUT
//  dut_s         in   WIDTH      DUT sum
//  dut_c         in   1          DUT carry-out
//  settle_valid  out  1          1-cycle pulse: settle_cycles valid
//  settle_cycles out  CNT_W      settle time of last completed transition
//  max_delay     out  CNT_W      largest settle_cycles since reset
//  worst_from    out  2*WIDTH+1  {a,b,c0} before worst transition
//  worst_to      out  2*WIDTH+1  {a,b,c0} after worst transition
//  trans_count   out  16         transitions seen while en=1, saturating at 16'hFFFF
//  timeout_err   out  1          sticky: a transition did not settle within TIMEOUT
//  mismatch      out  1          sticky: output deviated from golden while STABLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_q, cnt and all outputs cleared to 0 immediately, including mid-SETTLING.
//  golden = a + b + c0, zero-extended to WIDTH+1 bits; compare target is {dut_c,dut_s}.
//  in_q <= {a,b,c0} every clock, in every state. Transition = ({a,b,c0} != in_q) at a clock edge.
//  States:
//   IDLE:     en=0; no measurement; stats held. en=1 -> STABLE (no transition counted on entry).
//   STABLE:   transition -> trans_count++, from_q<=in_q, to_q<={a,b,c0}, cnt<=0. Compare at that same edge:
//             if output==golden, report settle 0 and stay STABLE; else go SETTLING with cnt<=1.
//   SETTLING: output==golden -> settle_cycles<=cnt, settle_valid<=1, go STABLE.
//             Otherwise cnt++; when cnt reaches TIMEOUT -> timeout_err<=1, go STABLE, no report.
//             A new transition abandons the current measurement (no report, no max update).
//             It is then handled exactly as the STABLE transition case.
//  Max update on report: only if settle_cycles > max_delay (strict). Ties keep the earliest.
//  On update, worst_from<=from_q and worst_to<=to_q.
//  en=0 in any state -> IDLE next edge; in-flight measurement dropped; outputs held.
//  settle_valid is high for exactly one cycle per report, registered (1 clk after the matching edge).
//  Sticky flags clear only on reset.
// CONFIGURATION
//  GLITCH_CHECK_EN defined: in STABLE with no transition at the edge, output!=golden sets mismatch.
//  GLITCH_CHECK_EN undefined: comparison logic removed; mismatch tied to 0.
// TESTING
//  1 rst, en=1, 000+000+0 -> 111+111+1, zero-delay DUT model: settle_valid pulse; settle_cycles=0; trans_count=1.
//  2 011+001+1 -> 100+011+0, DUT outputs correct 5 clk late: settle_cycles=5, max_delay=5,
//    worst_from=7'b0110011, worst_to=7'b1000110.
//  3 Second transition also settles in 5: max_delay=5, worst_from/worst_to unchanged (earliest kept).
//  4 DUT stuck at 0 after 001+001+0 -> 001+001+1: timeout_err=1 after 63 clk; no settle_valid; max_delay unchanged.
//  5 New transition at cnt=2 in SETTLING: trans_count += 2; exactly one settle_valid, for the second transition.
//  6 GLITCH_CHECK_EN set: dut_s flips for 1 clk while STABLE -> mismatch=1 and stays 1.
//    Macro unset: mismatch stays 0. rst_n low mid-SETTLING -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/adder_settle_monitor.sv
// Response-side settle monitor for WIDTH-bit gate-level adders: measures cycles from each
// input transition until {dut_c,dut_s} matches the golden sum. Optional macro: GLITCH_CHECK_EN.
module adder_settle_monitor #(
    parameter int WIDTH   = 3,
    parameter int TIMEOUT = 63,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               c0,
    input  logic [WIDTH-1:0]   dut_s,
    input  logic               dut_c,
    output logic               settle_valid,
    output logic [CNT_W-1:0]   settle_cycles,
    output logic [CNT_W-1:0]   max_delay,
    output logic [2*WIDTH:0]   worst_from,
    output logic [2*WIDTH:0]   worst_to,
    output logic [15:0]        trans_count,
    output logic               timeout_err,
    output logic               mismatch
);

    localparam int IN_W = 2*WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STABLE   = 2'd1,
        SETTLING = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   in_cur, in_q;
    logic [IN_W-1:0]   from_q, to_q;
    logic [IN_W-1:0]   rep_from, rep_to;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]    golden;
    logic              transition;
    logic              match;
    logic              start;
    logic              report;
    logic [CNT_W-1:0]  report_val;
    logic              timeout_set;
`ifdef GLITCH_CHECK_EN
    logic              glitch_set;
`endif

    assign in_cur     = {a, b, c0};
    assign transition = (in_cur != in_q);
    assign golden     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c0};
    assign match      = ({dut_c, dut_s} == golden);

    // A zero-cycle report happens at the transition edge itself, before from_q/to_q load.
    assign rep_from = start ? in_q   : from_q;
    assign rep_to   = start ? in_cur : to_q;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start       = 1'b0;
        report      = 1'b0;
        report_val  = '0;
        timeout_set = 1'b0;
`ifdef GLITCH_CHECK_EN
        glitch_set  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (en) state_d = STABLE;
            end
            STABLE, SETTLING: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (transition) begin
                    // A transition during SETTLING abandons the old measurement and restarts.
                    start = 1'b1;
                    if (match) begin
                        report     = 1'b1;
                        report_val = '0;
                        cnt_d      = '0;
                        state_d    = STABLE;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = SETTLING;
                    end
                end else if (state_q == SETTLING) begin
                    if (match) begin
                        report     = 1'b1;
                        report_val = cnt_q;
                        state_d    = STABLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        timeout_set = 1'b1;
                        state_d     = STABLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
`ifdef GLITCH_CHECK_EN
                    glitch_set = !match;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            in_q          <= '0;
            cnt_q         <= '0;
            from_q        <= '0;
            to_q          <= '0;
            settle_valid  <= 1'b0;
            settle_cycles <= '0;
            max_delay     <= '0;
            worst_from    <= '0;
            worst_to      <= '0;
            trans_count   <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_q         <= in_cur;
            cnt_q        <= cnt_d;
            settle_valid <= report;
            if (start) begin
                from_q <= in_q;
                to_q   <= in_cur;
                if (trans_count != 16'hFFFF) trans_count <= trans_count + 16'd1;
            end
            if (report) begin
                settle_cycles <= report_val;
                // Strict compare: on a tie the earliest worst transition is kept.
                if (report_val > max_delay) begin
                    max_delay  <= report_val;
                    worst_from <= rep_from;
                    worst_to   <= rep_to;
                end
            end
            if (timeout_set) timeout_err <= 1'b1;
        end
    end

`ifdef GLITCH_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          mismatch <= 1'b0;
        else if (glitch_set) mismatch <= 1'b1;
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_adder_settle_monitor.sv
// Directed bench for adder_settle_monitor: a scoreboard queue holds expected settle times,
// popped whenever settle_valid pulses; state outputs are checked with immediate assertions.
module tb_adder_settle_monitor;

    localparam int W  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [W-1:0]  a, b, dut_s;
    logic          c0, dut_c;
    logic          settle_valid;
    logic [CW-1:0] settle_cycles, max_delay;
    logic [2*W:0]  worst_from, worst_to;
    logic [15:0]   trans_count;
    logic          timeout_err, mismatch;

    int compared   = 0;
    int mismatched = 0;
    int sb[$];
    logic exp_glitch;

    adder_settle_monitor #(.WIDTH(W), .TIMEOUT(63), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a(a), .b(b), .c0(c0), .dut_s(dut_s), .dut_c(dut_c),
        .settle_valid(settle_valid), .settle_cycles(settle_cycles),
        .max_delay(max_delay), .worst_from(worst_from), .worst_to(worst_to),
        .trans_count(trans_count), .timeout_err(timeout_err), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] golden(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, z};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
        a  = na;
        b  = nb;
        c0 = nc;
    endtask

    task automatic set_dut(input logic [W:0] v);
        {dut_c, dut_s} = v;
    endtask

    // Applies a transition; the DUT output follows the golden sum 'delay' edges later.
    task automatic transition(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc,
                              input int delay);
        set_in(na, nb, nc);
        sb.push_back(delay);
        if (delay == 0) set_dut(golden(na, nb, nc));
        tick();
        if (delay > 0) begin
            repeat (delay - 1) tick();
            set_dut(golden(na, nb, nc));
            tick();
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (settle_valid === 1'b1) begin
            check("valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("settle_cycles_sb", settle_cycles, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef GLITCH_CHECK_EN
        exp_glitch = 1'b1;
`else
        exp_glitch = 1'b0;
`endif
        rst_n = 1'b0;
        en    = 1'b0;
        set_in(0, 0, 0);
        set_dut(0);
        #1;
        check("rst_settle_valid", settle_valid, 0);
        check("rst_max_delay", max_delay, 0);
        check("rst_trans_count", trans_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_worst_from", worst_from, 0);
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        tick();

        // 1: zero-delay transition
        transition(3'b111, 3'b111, 1'b1, 0);
        check("t1_trans_count", trans_count, 1);
        check("t1_settle_cycles", settle_cycles, 0);
        check("t1_max_delay", max_delay, 0);

        // 2: 011+001+1 -> 100+011+0, output correct 5 clocks late
        transition(3'b011, 3'b001, 1'b1, 0);
        transition(3'b100, 3'b011, 1'b0, 5);
        check("t2_settle_cycles", settle_cycles, 5);
        check("t2_max_delay", max_delay, 5);
        check("t2_worst_from", worst_from, 7'b0110011);
        check("t2_worst_to", worst_to, 7'b1000110);

        // 3: tie at 5 keeps the earliest worst transition
        transition(3'b001, 3'b001, 1'b1, 5);
        check("t3_max_delay", max_delay, 5);
        check("t3_worst_from", worst_from, 7'b0110011);
        check("t3_worst_to", worst_to, 7'b1000110);
        check("t3_trans_count", trans_count, 4);

        // 4: stuck-at-0 output after 001+001+0 -> 001+001+1
        transition(3'b001, 3'b001, 1'b0, 0);
        set_in(3'b001, 3'b001, 1'b1);
        set_dut(0);
        tick();
        repeat (62) tick();
        check("t4_timeout_early", timeout_err, 0);
        tick();
        check("t4_timeout_set", timeout_err, 1);
        set_dut(golden(3'b001, 3'b001, 1'b1));
        tick();
        check("t4_max_delay", max_delay, 5);
        check("t4_trans_count", trans_count, 6);
        check("t4_timeout_sticky", timeout_err, 1);

        // 5: new transition while SETTLING at cnt=2
        set_in(3'b010, 3'b010, 1'b0);
        tick();
        tick();
        transition(3'b101, 3'b001, 1'b0, 3);
        check("t5_trans_count", trans_count, 8);
        check("t5_settle_cycles", settle_cycles, 3);
        check("t5_max_delay", max_delay, 5);
        check("t5_sb_drained", sb.size(), 0);

        // 6: one-cycle glitch on dut_s while STABLE
        set_dut(golden(3'b101, 3'b001, 1'b0) ^ 4'b0001);
        tick();
        set_dut(golden(3'b101, 3'b001, 1'b0));
        tick();
        check("t6_mismatch", mismatch, exp_glitch);
        tick();
        tick();
        check("t6_mismatch_hold", mismatch, exp_glitch);

        // 7: en dropped mid-measurement: no report, no count on re-entry
        set_in(3'b000, 3'b000, 1'b1);
        tick();
        en = 1'b0;
        tick();
        set_dut(golden(3'b000, 3'b000, 1'b1));
        tick();
        tick();
        en = 1'b1;
        tick();
        tick();
        check("t7_trans_count", trans_count, 9);
        check("t7_settle_cycles", settle_cycles, 3);

        // 8: asynchronous reset in the middle of SETTLING
        set_in(3'b011, 3'b011, 1'b0);
        tick();
        check("t8_trans_count_pre", trans_count, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t8_trans_count", trans_count, 0);
        check("t8_max_delay", max_delay, 0);
        check("t8_settle_cycles", settle_cycles, 0);
        check("t8_worst_to", worst_to, 0);
        check("t8_timeout_err", timeout_err, 0);
        check("t8_mismatch", mismatch, 0);
        check("t8_settle_valid", settle_valid, 0);
        tick();
        check("end_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
